// File: rtl/wingbutled_debounce_if.sv
// Button/LED wing button bus: raw buttons in, conditioned levels and pulses out.
// The master drives the raw buttons; the slave is the debouncer.
interface wingbutled_debounce_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] btn_raw;
   logic [WIDTH-1:0] btn_level;
   logic [WIDTH-1:0] btn_press;
   logic [WIDTH-1:0] btn_release;
   logic             btn_any;

   modport master (
      output btn_raw,
      input  btn_level,
      input  btn_press,
      input  btn_release,
      input  btn_any
   );

   modport slave (
      input  btn_raw,
      output btn_level,
      output btn_press,
      output btn_release,
      output btn_any
   );
endinterface

// File: rtl/wingbutled_debounce.sv
// Per-button two-flop synchroniser and stability-counter debouncer producing
// clean levels, one-cycle press/release pulses and a registered any-pressed flag.
module wingbutled_debounce #(
   parameter int WIDTH       = 4,
   parameter int BOARD_CK    = 32000000,
   parameter int DEBOUNCE_US = 5000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   wingbutled_debounce_if.slave  bus
);

   localparam int N  = BOARD_CK / 1000000 * DEBOUNCE_US;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   localparam logic [CW-1:0] CNT_MAX  = CW'(N - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);

   generate
      if (N < 2) begin : g_n_check
         $error("wingbutled_debounce: debounce length must be at least 2 cycles");
      end
   endgenerate

   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;
   logic [WIDTH-1:0] stable_q;
   logic [WIDTH-1:0] stable_d;
   logic [WIDTH-1:0] press_q;
   logic [WIDTH-1:0] press_d;
   logic [WIDTH-1:0] release_q;
   logic [WIDTH-1:0] release_d;
   logic             any_q;
   logic             any_d;
   logic [CW-1:0]    cnt_q [WIDTH];
   logic [CW-1:0]    cnt_d [WIDTH];

   // Two-flop synchroniser; only the second stage feeds the debounce logic.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= bus.btn_raw;
         sync2_q <= sync1_q;
      end
   end

   // Per-bit stability counter: N consecutive disagreeing edges commit the new level.
   always_comb begin
      stable_d  = stable_q;
      press_d   = '0;
      release_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync2_q[i] == stable_q[i]) begin
            cnt_d[i] = CNT_ZERO;
         end else if (cnt_q[i] == CNT_MAX) begin
            stable_d[i]  = sync2_q[i];
            cnt_d[i]     = CNT_ZERO;
            press_d[i]   = sync2_q[i];
            release_d[i] = ~sync2_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end
      end
      any_d = |stable_d;
   end

   // Debounce state and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_q  <= '0;
         press_q   <= '0;
         release_q <= '0;
         any_q     <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= CNT_ZERO;
         end
      end else begin
         stable_q  <= stable_d;
         press_q   <= press_d;
         release_q <= release_d;
         any_q     <= any_d;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign bus.btn_level   = stable_q;
   assign bus.btn_press   = press_q;
   assign bus.btn_release = release_q;
   assign bus.btn_any     = any_q;

endmodule

// File: tb/tb_wingbutled_debounce.sv
// Bench for wingbutled_debounce with N = 8: directed vector table, hand-written
// reset sequences and randomized bouncing checked against a sample-window model.
module tb_wingbutled_debounce;

   localparam int W  = 4;
   localparam int N  = 8;
   localparam int HL = N + 2;

   typedef struct {
      logic [W-1:0] raw;
      int           hold;
      logic [W-1:0] level;
      logic [W-1:0] press;
      logic [W-1:0] rel;
      logic         any;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_vec = 0;
   int   n_bad = 0;

   // Model: raw value sampled at each of the last HL edges, newest at index 0.
   logic [W-1:0] hist [HL];
   logic [W-1:0] m_level;
   logic [W-1:0] m_press;
   logic [W-1:0] m_rel;

   vec_t tbl [$];

   wingbutled_debounce_if #(.WIDTH(W)) bus_if ();

   wingbutled_debounce #(
      .WIDTH      (W),
      .BOARD_CK   (1000000),
      .DEBOUNCE_US(8)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus_if)
   );

   always #5 clk = ~clk;

   function automatic logic [3*W:0] dut_out();
      return {bus_if.btn_level, bus_if.btn_press, bus_if.btn_release, bus_if.btn_any};
   endfunction

   task automatic check(input string name, input logic [3*W:0] act, input logic [3*W:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got lvl/prs/rel/any=%b_%b_%b_%b expected %b_%b_%b_%b",
                  name, $time, act[3*W:2*W+1], act[2*W:W+1], act[W:1], act[0],
                  exp[3*W:2*W+1], exp[2*W:W+1], exp[W:1], exp[0]);
      end
   endtask

   task automatic model_reset();
      for (int j = 0; j < HL; j++) hist[j] = '0;
      m_level = '0;
      m_press = '0;
      m_rel   = '0;
   endtask

   // A level flips when the raw samples the debouncer saw on the last N edges
   // (sampled 2..N+1 edges ago, due to the synchroniser) all disagree with it.
   task automatic model_edge(input logic [W-1:0] raw);
      logic flip;
      for (int j = HL - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = raw;
      for (int b = 0; b < W; b++) begin
         flip = 1'b1;
         for (int j = 2; j < HL; j++) begin
            if (hist[j][b] == m_level[b]) flip = 1'b0;
         end
         m_press[b] = flip & ~m_level[b];
         m_rel[b]   = flip & m_level[b];
         if (flip) m_level[b] = ~m_level[b];
      end
   endtask

   task automatic cycle(input logic [W-1:0] raw);
      bus_if.btn_raw = raw;
      @(posedge clk);
      if (!reset_n) model_reset();
      else model_edge(raw);
      #1;
      check("model", dut_out(), {m_level, m_press, m_rel, |m_level});
   endtask

   task automatic hold(input logic [W-1:0] raw, input int n);
      for (int c = 0; c < n; c++) cycle(raw);
   endtask

   initial begin
      model_reset();

      // Directed vectors: each row holds raw for `hold` edges, then checks the result.
      tbl.push_back('{4'b0000, 3,  4'b0000, 4'b0000, 4'b0000, 1'b0});
      tbl.push_back('{4'b0001, 8,  4'b0000, 4'b0000, 4'b0000, 1'b0});
      tbl.push_back('{4'b0001, 1,  4'b0000, 4'b0000, 4'b0000, 1'b0});
      tbl.push_back('{4'b0001, 1,  4'b0001, 4'b0001, 4'b0000, 1'b1});
      tbl.push_back('{4'b0001, 1,  4'b0001, 4'b0000, 4'b0000, 1'b1});
      tbl.push_back('{4'b0000, 10, 4'b0000, 4'b0000, 4'b0001, 1'b0});
      tbl.push_back('{4'b0000, 1,  4'b0000, 4'b0000, 4'b0000, 1'b0});
      tbl.push_back('{4'b1010, 10, 4'b1010, 4'b1010, 4'b0000, 1'b1});
      tbl.push_back('{4'b1010, 1,  4'b1010, 4'b0000, 4'b0000, 1'b1});
      tbl.push_back('{4'b0000, 10, 4'b0000, 4'b0000, 4'b1010, 1'b0});
      tbl.push_back('{4'b0000, 3,  4'b0000, 4'b0000, 4'b0000, 1'b0});
      tbl.push_back('{4'b0010, 3,  4'b0000, 4'b0000, 4'b0000, 1'b0});
      tbl.push_back('{4'b0000, 3,  4'b0000, 4'b0000, 4'b0000, 1'b0});
      tbl.push_back('{4'b0010, 3,  4'b0000, 4'b0000, 4'b0000, 1'b0});
      tbl.push_back('{4'b0000, 3,  4'b0000, 4'b0000, 4'b0000, 1'b0});
      tbl.push_back('{4'b0010, 8,  4'b0000, 4'b0000, 4'b0000, 1'b0});
      tbl.push_back('{4'b0010, 1,  4'b0000, 4'b0000, 4'b0000, 1'b0});
      tbl.push_back('{4'b0010, 1,  4'b0010, 4'b0010, 4'b0000, 1'b1});
      tbl.push_back('{4'b0010, 1,  4'b0010, 4'b0000, 4'b0000, 1'b1});
      tbl.push_back('{4'b0000, 10, 4'b0000, 4'b0000, 4'b0010, 1'b0});

      // Reset with all buttons pressed: outputs stay 0.
      bus_if.btn_raw = 4'hF;
      #1;
      check("reset_t0", dut_out(), 13'b0);
      hold(4'hF, 3);
      check("reset_held", dut_out(), 13'b0);
      bus_if.btn_raw = 4'h0;
      reset_n = 1'b1;

      for (int r = 0; r < tbl.size(); r++) begin
         hold(tbl[r].raw, tbl[r].hold);
         check($sformatf("table_row%0d", r), dut_out(),
               {tbl[r].level, tbl[r].press, tbl[r].rel, tbl[r].any});
      end

      // Bit 3 pressed, then bit 2 pressed and reset after 5 disagreeing edges.
      hold(4'b1000, 10);
      check("b3_press", dut_out(), {4'b1000, 4'b1000, 4'b0000, 1'b1});
      hold(4'b1100, 7);
      check("b2_pending", dut_out(), {4'b1000, 4'b0000, 4'b0000, 1'b1});
      #3 reset_n = 1'b0;
      #1;
      check("async_reset", dut_out(), 13'b0);
      model_reset();
      hold(4'b1100, 2);
      reset_n = 1'b1;
      hold(4'b1100, 9);
      check("no_early_pulse", dut_out(), 13'b0);
      hold(4'b1100, 1);
      check("fresh_press", dut_out(), {4'b1100, 4'b1100, 4'b0000, 1'b1});
      hold(4'b1100, 1);
      check("fresh_press_end", dut_out(), {4'b1100, 4'b0000, 4'b0000, 1'b1});

      // Random bouncing against the model.
      begin
         logic [W-1:0] raw;
         raw = 4'b1100;
         for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < W; b++) begin
               if ($urandom_range(9, 0) == 0) raw[b] = ~raw[b];
            end
            cycle(raw);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
